prv32_div_unit: RTL
===================

PRV32_DIV_UNIT -- requirements
Module: prv32_div_unit

Interface
REQ-001 The block SHALL have parameter FAST_SPECIAL, default 1, meaning: divide-by-zero and signed-overflow requests complete without iterating.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, the request strobe.
REQ-005 The block SHALL have port op, input, 2, the operation code: 00 DIV, 01 DIVU, 10 REM, 11 REMU (same encoding as ALU function codes 110_xx).
REQ-006 The block SHALL have ports a and b, input, 32 each, the dividend and divisor.
REQ-007 The block SHALL have port flush, input, 1, the pipeline squash that abandons the in-flight operation.
REQ-008 The block SHALL have port busy, output, 1, which is high while iterating.
REQ-009 The block SHALL have port done, output, 1, a one-cycle result-valid pulse.
REQ-010 The block SHALL have port r, output, 32, the result register.

Function
REQ-011 The block SHALL implement states IDLE, BUSY and DONE.
REQ-012 The block SHALL accept start at a rising edge only when the state is IDLE or DONE and flush=0.
REQ-013 On acceptance, the block SHALL capture a, b and op internally; subsequent changes to a, b and op SHALL NOT affect the result.
REQ-014 In the normal case, acceptance SHALL move the state to BUSY with an iteration counter of 0; busy=1 in BUSY only.
REQ-015 BUSY SHALL run a restoring radix-2 loop of exactly 32 iteration cycles, then move to DONE, so that done is high in the 33rd cycle after the accept edge.
REQ-016 DONE SHALL last exactly one cycle with done=1, then move to IDLE unless a new start is accepted in that cycle.
REQ-017 r SHALL update only on entry to DONE and SHALL hold its value until the next DONE or reset.
REQ-018 Signed ops (DIV, REM) SHALL divide operand magnitudes unsigned; the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-019 Unsigned ops (DIVU, REMU) SHALL treat a and b as unsigned 32-bit values.
REQ-020 DIV and REM results SHALL satisfy a = q*b + rem, with |rem| < |b|, truncating toward zero.
REQ-021 Divide-by-zero (b=0) SHALL give a quotient of 0xFFFFFFFF for both DIV and DIVU, and a remainder equal to a.
REQ-022 Signed overflow (DIV/REM with a=0x80000000 and b=0xFFFFFFFF) SHALL give a quotient of 0x80000000 and a remainder of 0.
REQ-023 With FAST_SPECIAL=1, special cases SHALL go IDLE/DONE -> DONE directly: done is high 1 cycle after accept and busy is never asserted.
REQ-024 With FAST_SPECIAL=0, special cases SHALL iterate like normal requests while producing the REQ-021/022 values.
REQ-025 A start asserted while in BUSY SHALL be ignored and not queued.
REQ-026 flush=1 in BUSY SHALL return the state to IDLE at the next edge, with no done pulse and r unchanged.
REQ-027 flush=1 in DONE SHALL NOT suppress that done pulse, but SHALL block acceptance of a simultaneous start.
REQ-028 flush=1 together with start in IDLE SHALL drop the start.
REQ-029 Back-to-back operation SHALL be supported: a start accepted in DONE begins the next operation, giving a 33-cycle issue interval.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, r=0x00000000, the iteration counter to 0, and the internal operand registers to 0.
REQ-031 Reset asserted mid-BUSY SHALL abandon the operation; no done SHALL follow reset release.
REQ-032 The first start SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-033 The bench SHALL apply DIV with a=0xFFFFFFF9 (-7), b=0x00000002 and require done exactly 33 cycles after the accept edge with r=0xFFFFFFFD, and busy high for exactly 32 cycles.
REQ-034 The bench SHALL apply REM with -7 and 2 and require r=0xFFFFFFFF; it SHALL also apply REMU with 0xFFFFFFF9 and 2 and require r=0x00000001, and DIVU with 0xFFFFFFF9 and 2 and require r=0x7FFFFFFC.
REQ-035 With FAST_SPECIAL=1, the bench SHALL apply DIVU with a=5, b=0 and require r=0xFFFFFFFF with done 1 cycle after accept and busy never high; it SHALL apply REM with a=5, b=0 and require r=0x00000005.
REQ-036 The bench SHALL apply DIV with 0x80000000 and 0xFFFFFFFF and require r=0x80000000; it SHALL apply REM with the same operands and require r=0x00000000; it SHALL repeat both with FAST_SPECIAL=0 and require a 33-cycle latency.
REQ-037 The bench SHALL assert flush on the 10th BUSY cycle and require busy=0 the next cycle, no done pulse, and r retaining its prior value; a start on the following cycle SHALL be accepted and complete correctly.
REQ-038 The bench SHALL pulse rst mid-BUSY, asynchronously between clock edges, and require busy=0, done=0 and r=0 before the next edge, with no done after release.

Source files
------------

// File: rtl/prv32_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and overflow may bypass the loop.
module prv32_div_unit #(
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] r
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_res;

  logic        w_accept;
  logic        w_spec_in;
  logic [31:0] w_amag;
  logic [31:0] w_div;
  logic [32:0] w_sh;
  logic [32:0] w_trial;
  logic        w_ge;
  logic [31:0] w_rem_n;
  logic [31:0] w_quo_n;

  // Final sign fix-up, with RISC-V defined results for b=0 and overflow.
  function automatic logic [31:0] fin(
    input logic [1:0]  f,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] q,
    input logic [31:0] rm
  );
    logic sgn;
    logic isrem;
    sgn   = ~f[0];
    isrem = f[1];
    if (y == 32'd0)
      fin = isrem ? x : 32'hFFFF_FFFF;
    else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      fin = isrem ? 32'd0 : 32'h8000_0000;
    else if (isrem)
      fin = (sgn && x[31]) ? -rm : rm;
    else
      fin = (sgn && (x[31] ^ y[31])) ? -q : q;
  endfunction

  assign w_accept  = start && !flush &&
                     (r_state == S_IDLE || r_state == S_DONE);
  assign w_spec_in = (b == 32'd0) ||
                     (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  assign w_amag    = (!op[0] && a[31]) ? -a : a;
  assign w_div     = (!r_op[0] && r_b[31]) ? -r_b : r_b;

  assign w_sh    = {r_rem, r_quo[31]};
  assign w_trial = w_sh - {1'b0, w_div};
  assign w_ge    = ~w_trial[32];
  assign w_rem_n = w_ge ? w_trial[31:0] : w_sh[31:0];
  assign w_quo_n = {r_quo[30:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= 2'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_res   <= 32'd0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_op  <= op;
      r_cnt <= 5'd0;
      r_rem <= 32'd0;
      r_quo <= w_amag;
      if (FAST_SPECIAL && w_spec_in) begin
        r_state <= S_DONE;
        r_res   <= fin(op, a, b, 32'd0, 32'd0);
      end else begin
        r_state <= S_BUSY;
      end
    end else if (r_state == S_BUSY) begin
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        r_rem <= w_rem_n;
        r_quo <= w_quo_n;
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_state <= S_DONE;
          r_res   <= fin(r_op, r_a, r_b, w_quo_n, w_rem_n);
        end
      end
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end
  end

  assign busy = (r_state == S_BUSY);
  assign done = (r_state == S_DONE);
  assign r    = r_res;

endmodule
